// File: rtl/au_pkg.sv
// Shared constants, opcodes, FSM state type and saturation helper for the AU executor.
// Optional divider is selected with the AU_DIV_EN macro.
package au_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned FRAC_W   = 8;
    localparam int unsigned REG_N    = 32;
    localparam int unsigned DIV_ITER = 24;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } au_state_t;

    // Clamp a wide signed intermediate into the signed 16-bit Q8.8 range.
    function automatic logic [DATA_W-1:0] sat16(input logic signed [33:0] v);
        if (v > 34'sd32767) begin
            return 16'h7FFF;
        end else if (v < -34'sd32768) begin
            return 16'h8000;
        end else begin
            return v[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/au_divider.sv
// Iterative 24-step restoring divider: (dividend<<8)/divisor on magnitudes.
// Present only when AU_DIV_EN is defined.
`ifdef AU_DIV_EN
module au_divider
    import au_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DATA_W-1:0]        dividend,
    input  logic [DATA_W-1:0]        divisor,
    output logic                     done,
    output logic [DATA_W+FRAC_W-1:0] quotient
);

    logic                     running;
    logic [4:0]               cnt;
    logic [DATA_W-1:0]        rem;
    logic [DATA_W-1:0]        dsr;
    logic [DATA_W+FRAC_W-1:0] dvd;

    logic [DATA_W:0]          shift;
    logic                     ge;
    logic [DATA_W-1:0]        rem_n;
    logic [DATA_W+FRAC_W-1:0] dvd_n;

    // Quotient bits are shifted into the dividend register as its bits drain out.
    always_comb begin
        shift = {rem, dvd[DATA_W+FRAC_W-1]};
        ge    = shift >= {1'b0, dsr};
        rem_n = ge ? 16'(shift - {1'b0, dsr}) : shift[DATA_W-1:0];
        dvd_n = {dvd[DATA_W+FRAC_W-2:0], ge};
    end

    // done flags the edge that performs the final step; quotient is that step's result.
    assign done     = running && (cnt == 5'(DIV_ITER - 1));
    assign quotient = dvd_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
            rem     <= '0;
            dsr     <= '0;
            dvd     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            rem     <= '0;
            dsr     <= divisor;
            dvd     <= {dividend, {FRAC_W{1'b0}}};
        end else if (running) begin
            rem     <= rem_n;
            dvd     <= dvd_n;
            cnt     <= cnt + 5'd1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/au_executor.sv
// Arithmetic unit executor: 32x16 Q8.8 register file, ADD/SUB/MUL/DIV with saturation.
// AU_DIV_EN includes the iterative divider; without it DIV flags div_zero and returns 0.
module au_executor
    import au_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ctl_a,
    input  logic [4:0]        ctl_b,
    input  logic [1:0]        ctl_c,
    input  logic [1:0]        ctl_d,
    input  logic              ctl_e,
    input  logic              ctl_f,
    output logic              continue_o,
    output logic              busy,
    output logic [15:0]       result,
    output logic              div_zero,
    output logic              start_drop,
    input  logic              host_we,
    input  logic [4:0]        host_waddr,
    input  logic [15:0]       host_wdata,
    input  logic [4:0]        host_raddr,
    output logic [15:0]       host_rdata
);

    logic [DATA_W-1:0] regs [REG_N];
    au_state_t         state;
    logic [DATA_W-1:0] op_a, op_b;
    logic [1:0]        op_d;
    logic              op_f;
    logic [4:0]        op_dst;

    logic              start_ok, complete, dz, wb_ok, wb;
    logic signed [33:0] a_x, b_x;
    logic [DATA_W-1:0] alu_res, div_res;
    logic              dbg_unused;

    assign dbg_unused = ^ctl_c;
    assign start_ok   = (state == ST_IDLE) && ctl_e;
    assign busy       = (state != ST_IDLE);

`ifdef AU_DIV_EN
    logic                     div_done;
    logic [DATA_W+FRAC_W-1:0] div_q;
    logic [DATA_W-1:0]        rd_a, rd_b;
    logic signed [33:0]       q_x;

    assign rd_a = regs[ctl_a];
    assign rd_b = regs[ctl_b];

    au_divider u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (start_ok && (ctl_d == OP_DIV)),
        .dividend (rd_a[DATA_W-1] ? 16'(-rd_a) : rd_a),
        .divisor  (rd_b[DATA_W-1] ? 16'(-rd_b) : rd_b),
        .done     (div_done),
        .quotient (div_q)
    );

    always_comb begin
        q_x      = $signed({10'b0, div_q});
        dz       = (op_b == '0);
        div_res  = dz ? (op_a[DATA_W-1] ? 16'h8000 : 16'h7FFF)
                      : sat16((op_a[DATA_W-1] ^ op_b[DATA_W-1]) ? -q_x : q_x);
        complete = (state == ST_EXEC) && ((op_d != OP_DIV) || div_done);
        wb_ok    = op_f;
    end
`else
    always_comb begin
        dz       = 1'b1;
        div_res  = '0;
        complete = (state == ST_EXEC);
        wb_ok    = op_f && (op_d != OP_DIV);
    end
`endif

    always_comb begin
        a_x     = $signed({{18{op_a[DATA_W-1]}}, op_a});
        b_x     = $signed({{18{op_b[DATA_W-1]}}, op_b});
        alu_res = '0;
        case (op_d)
            OP_ADD:  alu_res = sat16(a_x + b_x);
            OP_SUB:  alu_res = sat16(a_x - b_x);
            OP_MUL:  alu_res = sat16((a_x * b_x) >>> FRAC_W);
            default: alu_res = div_res;
        endcase
    end

    assign wb = complete && wb_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_a       <= '0;
            op_b       <= '0;
            op_d       <= '0;
            op_f       <= 1'b0;
            op_dst     <= '0;
            continue_o <= 1'b0;
            result     <= '0;
            div_zero   <= 1'b0;
            start_drop <= 1'b0;
            host_rdata <= '0;
            for (int unsigned i = 0; i < REG_N; i++) begin
                regs[i] <= '0;
            end
        end else begin
            continue_o <= complete;
            host_rdata <= regs[host_raddr];
            if (ctl_e && (state != ST_IDLE)) begin
                start_drop <= 1'b1;
            end
            // Single write port: the AU writeback wins and a coincident host write is lost.
            if (wb) begin
                regs[op_dst] <= alu_res;
            end else if (host_we) begin
                regs[host_waddr] <= host_wdata;
            end
            case (state)
                ST_IDLE: begin
                    if (ctl_e) begin
                        op_a   <= regs[ctl_a];
                        op_b   <= regs[ctl_b];
                        op_d   <= ctl_d;
                        op_f   <= ctl_f;
                        op_dst <= ctl_a;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (complete) begin
                        result <= alu_res;
                        if ((op_d == OP_DIV) && dz) begin
                            div_zero <= 1'b1;
                        end
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_au_executor.sv
// Directed self-checking bench for au_executor; expectations follow AU_DIV_EN.
module tb_au_executor;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ctl_a, ctl_b;
    logic [1:0]  ctl_c, ctl_d;
    logic        ctl_e, ctl_f;
    logic        continue_o, busy, div_zero, start_drop;
    logic [15:0] result;
    logic        host_we;
    logic [4:0]  host_waddr, host_raddr;
    logic [15:0] host_wdata, host_rdata;

    int tests = 0;
    int fails = 0;

`ifdef AU_DIV_EN
    localparam int          DIV_LAT  = 25;
    localparam logic [15:0] DIV_RES  = 16'h00C0;
    localparam logic        DIV_DZ   = 1'b0;
    localparam logic [15:0] DZ_RES   = 16'h8000;
    localparam logic [15:0] DZ_R5    = 16'h8000;
    localparam logic [15:0] DROP_R1  = 16'h00C0;
`else
    localparam int          DIV_LAT  = 2;
    localparam logic [15:0] DIV_RES  = 16'h0000;
    localparam logic        DIV_DZ   = 1'b1;
    localparam logic [15:0] DZ_RES   = 16'h0000;
    localparam logic [15:0] DZ_R5    = 16'hFF00;
    localparam logic [15:0] DROP_R1  = 16'h0300;
`endif

    au_executor dut (
        .clk        (clk),
        .rst        (rst),
        .ctl_a      (ctl_a),
        .ctl_b      (ctl_b),
        .ctl_c      (ctl_c),
        .ctl_d      (ctl_d),
        .ctl_e      (ctl_e),
        .ctl_f      (ctl_f),
        .continue_o (continue_o),
        .busy       (busy),
        .result     (result),
        .div_zero   (div_zero),
        .start_drop (start_drop),
        .host_we    (host_we),
        .host_waddr (host_waddr),
        .host_wdata (host_wdata),
        .host_raddr (host_raddr),
        .host_rdata (host_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic hwrite(input logic [4:0] addr, input logic [15:0] data);
        host_we = 1'b1; host_waddr = addr; host_wdata = data;
        tick;
        host_we = 1'b0;
    endtask

    task automatic hread(input logic [4:0] addr, output logic [15:0] data);
        host_raddr = addr;
        tick;
        data = host_rdata;
    endtask

    // Start an op, then watch continue_o for 40 cycles; lat is the cycle index of the first pulse.
    task automatic run_op(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                          input logic f, input logic hold, output int lat, output int pulses);
        ctl_d = op; ctl_a = a; ctl_b = b; ctl_f = f; ctl_c = 2'b01; ctl_e = 1'b1;
        tick;
        if (!hold) ctl_e = 1'b0;
        lat = 0;
        pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            if (continue_o) begin
                pulses++;
                if (lat == 0) lat = k;
            end
            if (lat != 0 && k == lat + 1) ctl_e = 1'b0;
            tick;
        end
        ctl_e = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        tick;
    endtask

    initial begin
        logic [15:0] rd;
        int lat, pulses, seen;

        rst = 1'b1;
        ctl_a = '0; ctl_b = '0; ctl_c = '0; ctl_d = '0; ctl_e = 1'b0; ctl_f = 1'b0;
        host_we = 1'b0; host_waddr = '0; host_wdata = '0; host_raddr = '0;
        tick;
        tick;
        rst = 1'b0;
        #2;
        check("rst_result", result, 16'h0000);
        check("rst_busy", busy, 1'b0);
        check("rst_continue", continue_o, 1'b0);
        check("rst_div_zero", div_zero, 1'b0);
        check("rst_start_drop", start_drop, 1'b0);
        check("rst_rdata", host_rdata, 16'h0000);
        hread(5'd5, rd);
        check("rst_r5", rd, 16'h0000);

        hwrite(5'd1, 16'h0180);
        hwrite(5'd2, 16'h0200);
        host_we = 1'b1; host_waddr = 5'd3; host_wdata = 16'hABCD; host_raddr = 5'd3;
        tick;
        host_we = 1'b0;
        check("rd_same_edge_old", host_rdata, 16'h0000);
        tick;
        check("rd_after_write", host_rdata, 16'hABCD);
        hread(5'd1, rd);
        check("load_r1", rd, 16'h0180);

        run_op(2'b00, 5'd1, 5'd2, 1'b1, 1'b0, lat, pulses);
        check("add_latency", lat, 2);
        check("add_pulses", pulses, 1);
        check("add_result", result, 16'h0380);
        hread(5'd1, rd);
        check("add_wb_r1", rd, 16'h0380);

        hwrite(5'd1, 16'h0180);
        run_op(2'b10, 5'd1, 5'd2, 1'b0, 1'b0, lat, pulses);
        check("mul_latency", lat, 2);
        check("mul_result", result, 16'h0300);
        hread(5'd1, rd);
        check("mul_no_wb_r1", rd, 16'h0180);
        run_op(2'b01, 5'd2, 5'd1, 1'b0, 1'b0, lat, pulses);
        check("sub_result", result, 16'h0080);

        run_op(2'b11, 5'd1, 5'd2, 1'b0, 1'b1, lat, pulses);
        check("div_latency", lat, DIV_LAT);
        check("div_hold_pulses", pulses, 1);
        check("div_result", result, DIV_RES);
        check("div_dz_flag", div_zero, DIV_DZ);
        check("hold_start_drop", start_drop, 1'b1);

        do_reset;
        check("rst2_start_drop", start_drop, 1'b0);
        check("rst2_div_zero", div_zero, 1'b0);
        hwrite(5'd1, 16'h0180);
        hwrite(5'd2, 16'h0200);
        hwrite(5'd3, 16'h7000);
        hwrite(5'd4, 16'h0400);
        hwrite(5'd5, 16'hFF00);
        hwrite(5'd6, 16'h0000);
        hwrite(5'd7, 16'hFE80);
        hwrite(5'd8, 16'h8000);

        run_op(2'b10, 5'd3, 5'd4, 1'b0, 1'b0, lat, pulses);
        check("mul_sat_pos", result, 16'h7FFF);
        run_op(2'b00, 5'd3, 5'd3, 1'b0, 1'b0, lat, pulses);
        check("add_sat_pos", result, 16'h7FFF);
        run_op(2'b01, 5'd8, 5'd4, 1'b0, 1'b0, lat, pulses);
        check("sub_sat_neg", result, 16'h8000);
`ifdef AU_DIV_EN
        run_op(2'b11, 5'd7, 5'd2, 1'b0, 1'b0, lat, pulses);
        check("div_neg_result", result, 16'hFF40);
        check("div_neg_no_dz", div_zero, 1'b0);
`endif
        run_op(2'b11, 5'd5, 5'd6, 1'b1, 1'b0, lat, pulses);
        check("divz_latency", lat, DIV_LAT);
        check("divz_result", result, DZ_RES);
        check("divz_flag", div_zero, 1'b1);
        hread(5'd5, rd);
        check("divz_r5", rd, DZ_R5);

        ctl_d = 2'b00; ctl_a = 5'd1; ctl_b = 5'd2; ctl_f = 1'b1; ctl_e = 1'b1;
        tick;
        ctl_e = 1'b0;
        host_we = 1'b1; host_waddr = 5'd1; host_wdata = 16'h1234;
        tick;
        host_we = 1'b0;
        tick;
        hread(5'd1, rd);
        check("wb_beats_host", rd, 16'h0380);

        do_reset;
        check("rst3_start_drop", start_drop, 1'b0);
        hwrite(5'd1, 16'h0180);
        hwrite(5'd2, 16'h0200);
`ifdef AU_DIV_EN
        ctl_d = 2'b11;
`else
        ctl_d = 2'b10;
`endif
        ctl_a = 5'd1; ctl_b = 5'd2; ctl_f = 1'b1; ctl_e = 1'b1;
        tick;
`ifdef AU_DIV_EN
        ctl_e = 1'b0;
        repeat (4) tick;
`endif
        ctl_d = 2'b00; ctl_a = 5'd2; ctl_b = 5'd2; ctl_f = 1'b1; ctl_e = 1'b1;
        tick;
        ctl_e = 1'b0;
        seen = 0;
        for (int k = 0; k < 40 && seen == 0; k++) begin
            if (continue_o) seen = 1;
            else tick;
        end
        check("drop_completed", seen, 1);
        check("drop_flag", start_drop, 1'b1);
        check("drop_result", result, DROP_R1);
        tick;
        hread(5'd1, rd);
        check("drop_r1", rd, DROP_R1);
        hread(5'd2, rd);
        check("drop_r2_untouched", rd, 16'h0200);

        hwrite(5'd1, 16'h0180);
`ifdef AU_DIV_EN
        ctl_d = 2'b11;
`else
        ctl_d = 2'b00;
`endif
        ctl_a = 5'd1; ctl_b = 5'd2; ctl_f = 1'b1; ctl_e = 1'b1;
        tick;
        ctl_e = 1'b0;
`ifdef AU_DIV_EN
        repeat (9) tick;
`endif
        rst = 1'b1;
        #2;
        check("abort_busy", busy, 1'b0);
        #1;
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            tick;
            if (continue_o) pulses++;
        end
        check("abort_no_pulse", pulses, 0);
        check("abort_result", result, 16'h0000);
        hread(5'd1, rd);
        check("abort_r1_no_wb", rd, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
